// File: rtl/pwm_capture_if.sv
// pwm_capture_if: measurement results from the PWM capture block to its consumer.
interface pwm_capture_if #(parameter int CBITS = 18);
    logic [CBITS:0] high_len;
    logic [CBITS:0] period_len;
    logic [2:0]     duty_code;
    logic           code_ok;
    logic           meas_valid;
    logic           stuck;
    logic           stuck_level;
    modport master (output high_len, period_len, duty_code, code_ok, meas_valid, stuck, stuck_level);
    modport slave  (input  high_len, period_len, duty_code, code_ok, meas_valid, stuck, stuck_level);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input and recovers the generator duty code.
module pwm_capture #(parameter int CBITS = 18) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    pwm_capture_if.master m
);
    typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
    localparam logic [CBITS:0] frame_len = {1'b1, {CBITS{1'b0}}};
    state_t         state;
    logic           s1, s2, s3;
    logic [CBITS:0] hi_cnt, per_cnt, hi_inc, per_inc;
    logic           rise, fall, per_sat, frame_ok;
    always_comb begin
        rise     = s2 & ~s3;
        fall     = ~s2 & s3;
        per_sat  = &per_cnt;
        hi_inc   = &hi_cnt ? hi_cnt : hi_cnt + 1'b1;
        per_inc  = per_sat ? per_cnt : per_cnt + 1'b1;
        frame_ok = per_cnt == frame_len && hi_cnt[CBITS:CBITS-1] == 2'b00 &&
                   hi_cnt[CBITS-5] && hi_cnt[CBITS-6:0] == '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            state         <= WAIT_RISE;
            hi_cnt        <= '0;
            per_cnt       <= '0;
            m.high_len    <= '0;
            m.period_len  <= '0;
            m.duty_code   <= '0;
            m.code_ok     <= 1'b0;
            m.meas_valid  <= 1'b0;
            m.stuck       <= 1'b0;
            m.stuck_level <= 1'b0;
        end else begin
            s1           <= pwm_in;
            s2           <= s1;
            s3           <= s2;
            m.meas_valid <= 1'b0;
            // a rise beats counter saturation in the same cycle
            if (rise) begin
                if (state == MEAS_LOW) begin
                    m.high_len   <= hi_cnt;
                    m.period_len <= per_cnt;
                    m.duty_code  <= hi_cnt[CBITS-2:CBITS-4];
                    m.code_ok    <= frame_ok;
                    m.meas_valid <= 1'b1;
                end
                hi_cnt  <= {{CBITS{1'b0}}, 1'b1};
                per_cnt <= {{CBITS{1'b0}}, 1'b1};
                m.stuck <= 1'b0;
                state   <= MEAS_HIGH;
            end else if (per_sat) begin
                m.stuck       <= 1'b1;
                m.stuck_level <= s2;
                state         <= WAIT_RISE;
            end else begin
                per_cnt <= per_inc;
                if (state == MEAS_HIGH && s2)
                    hi_cnt <= hi_inc;
                if (state == MEAS_HIGH && fall)
                    state <= MEAS_LOW;
            end
        end
    end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the PWM_TOP generator. Samples a single-bit PWM waveform, measures high time and period in clock cycles, and recovers the 3-bit duty code (the generator's sw[3:1]) when the waveform matches the generator's fixed 2^CBITS-cycle frame. It sits on the far side of the PWM link and feeds a register/monitor stage that consumes one-cycle measurement strobes.

## Interface
- CBITS, 18, counter width of the matching generator; the frame period is 2^CBITS cycles. Minimum is 6.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- high_len  out  CBITS+1  high-phase length of the last complete period, in cycles.
- period_len  out  CBITS+1  rise-to-rise length of the last complete period, in cycles.
- duty_code  out  3  high_len[CBITS-2:CBITS-4].
- code_ok  out  1  the last period is a well-formed generator frame.
- meas_valid  out  1  one-cycle strobe; high_len, period_len, duty_code and code_ok were updated at this edge.
- stuck  out  1  no rising edge seen for 2^(CBITS+1)-1 cycles.
- stuck_level  out  1  synchronized input level, registered when stuck is set.

## Operation
- Synchronizer: pwm_in feeds s1, then s2, then s3 (three flops).
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
  - The FSM uses only s2, rise and fall.
- Counters: hi_cnt and per_cnt, each CBITS+1 bits.
  - Both saturate at all-ones and never wrap.
- FSM states are WAIT_RISE, MEAS_HIGH and MEAS_LOW. Reset enters WAIT_RISE.
- WAIT_RISE:
  - per_cnt increments every cycle.
  - On rise: hi_cnt is set to 1, per_cnt is set to 1, and the FSM goes to MEAS_HIGH.
  - No meas_valid is produced, because the first period after reset or stuck is partial.
- MEAS_HIGH:
  - Each cycle with s2=1 increments hi_cnt and per_cnt.
  - On fall: per_cnt increments, hi_cnt holds, and the FSM goes to MEAS_LOW.
- MEAS_LOW:
  - per_cnt increments every cycle.
  - On rise, all of the following happen at the same edge:
    - high_len <= hi_cnt and period_len <= per_cnt.
    - duty_code <= hi_cnt[CBITS-2:CBITS-4].
    - code_ok is updated.
    - meas_valid <= 1.
    - hi_cnt and per_cnt are set to 1, and the FSM goes to MEAS_HIGH.
- Result: a waveform high for H cycles out of a P-cycle period reports high_len=H and period_len=P exactly.
- code_ok=1 only when all of the following hold:
  - period_len == 2^CBITS;
  - high_len[CBITS:CBITS-1] == 0;
  - high_len[CBITS-5] == 1;
  - high_len[CBITS-6:0] == 0.
  - Otherwise code_ok=0, and duty_code is still updated from the raw bits.
- Stuck detection:
  - If per_cnt is all-ones in any state and no rise is present that cycle: stuck <= 1, stuck_level <= s2, and the FSM goes to WAIT_RISE.
  - In that case, no meas_valid is produced and the held results are unchanged.
  - Covers 0% duty (stuck_level=0) and 100% duty (stuck_level=1).
- stuck clears on the next rise, at the same edge that enters MEAS_HIGH.
- Rise and saturation in the same cycle: the rise wins, and stuck is not set.

## Timing
- Reset values: high_len=0, period_len=0, duty_code=0, code_ok=0, meas_valid=0, stuck=0, stuck_level=0.
  - The synchronizer flops and both counters are 0; the FSM is in WAIT_RISE.
- Reset asserted mid-measurement discards the partial period. After release, the first strobe follows the second rise.
- Latency: when pwm_in is first sampled high at edge k, the rise is acted on at edge k+2, and meas_valid is high from k+2 to k+3.
- meas_valid is never high for two consecutive cycles.
  - The minimum spacing between strobes equals the input period.
  - The minimum input period is 2 cycles (1 high, 1 low).
- Results hold between strobes, including while stuck=1.
- Glitch pulses of 1 cycle that survive the synchronizer are measured as-is. No filtering.

## Test plan
All scenarios use CBITS=8, so the frame is 256 cycles.
- Generator frame with code 5 (high 88, period 256), repeated 3 times → strobes on the 2nd and 3rd rise: high_len=88, period_len=256, duty_code=5, code_ok=1. No strobe on the 1st rise.
- Sweep code 0..7 (high = 16·code+8, period 256) → duty_code equals code and code_ok=1 for every frame.
- Arbitrary waveform with high 37, period 200 → high_len=37, period_len=200, code_ok=0.
- pwm_in held 0 after one valid frame → stuck=1 with stuck_level=0 exactly 511 cycles after the last rise was processed; results still show the prior frame. The next rise clears stuck, and the first strobe comes one full period later.
- pwm_in held 1 → stuck=1, stuck_level=1. Minimum waveform (1 high, 1 low) → strobes every 2 cycles with high_len=1, period_len=2.
- Assert rst in MEAS_LOW mid-frame → all outputs are 0 immediately (asynchronously). After release, no strobe until the second rise.
